boa_mem_arbiter: RTL
====================

// Module: boa_mem_arbiter
// PURPOSE
// - Shares one boa_mem_bus slave between two masters: port 0 (instruction fetch, boa_stage_if)
//   and port 1 (data access, MEM stage).
// - Grants by fixed priority with starvation relief, holds the grant through slave wait states,
//   and routes read data back to the port that issued the access.
// - Sits between the pipeline stages and the shared memory/peripheral bus.
// PARAMETERS
// - PRIO_P1       1  1: port 1 (data) wins simultaneous requests; 0: port 0 wins.
// - STARVE_LIMIT  4  consecutive lost arbitration cycles after which the losing port takes priority; range 1..15.
// PORTS
// - clk    in   1   clock; all state updates on posedge.
// - rst    in   1   synchronous reset, active-high.
// - p0bus  intf -   boa_mem_bus, slave side, fetch master (re, we[3:0], addr[31:2], wdata[31:0] in; ready, rdata[31:0] out).
// - p1bus  intf -   boa_mem_bus, slave side, data master; same signals.
// - mbus   intf -   boa_mem_bus, master side, shared bus; arbiter drives re/we/addr/wdata, samples ready/rdata.
// BEHAVIOUR
// - Request: port N requests when re | (|we). Access accepted in the cycle where it requests, holds
//   the grant and mbus.ready=1.
// - Read data: valid on the port's rdata in the cycle after acceptance (same 1-cycle latency as mbus).
// - Grant mux: combinational. mbus.re/we/addr/wdata = granted port's signals, else 0.
//   Granted port's ready = mbus.ready; non-granted port's ready = 0.
// - State: lock (0=IDLE, 1=LOCKED), lock_owner (1 bit), resp_owner (2 bits: none/P0/P1), starve_cnt (4 bits).
// - IDLE: grant = sole requester; if both request, priority port unless starve_cnt >= STARVE_LIMIT,
//   in which case the other port.
//   - If granted and mbus.ready=0: go LOCKED and set lock_owner = granted port.
// - LOCKED: grant forced to lock_owner regardless of other requests.
//   - Return to IDLE on the cycle mbus.ready=1 (access accepted).
//   - Master deasserting its request while locked (protocol violation): also return to IDLE,
//     no access is recorded.
// - resp_owner: on acceptance, set to granted port; otherwise set to none.
//   - rdata of the owning port = mbus.rdata; rdata of the other port = 0.
// - starve_cnt: +1 (saturating at 15) each cycle both ports request and the non-priority port is not granted.
//   - Cleared when the non-priority port has an access accepted.
//   - Unchanged otherwise.
// - Back-to-back: a new grant is decided in the same cycle a previous access is accepted;
//   no idle cycle is inserted.
// - Reset (any cycle, including mid-wait-state):
//   - lock=IDLE, resp_owner=none, starve_cnt=0.
//   - While rst=1: mbus.re=0, mbus.we=0, addr=0, wdata=0; both port ready=0, rdata=0.
//   - The in-flight access is abandoned.
// - Writes: wdata/we passed through unchanged.
//   - Write acceptance sets resp_owner like a read; the returned rdata is don't-care to the master.
// STRUCTURE
// - boa_pkg additions:
//   - typedef enum logic {ARB_IDLE, ARB_LOCKED} boa_arb_state_t;
//   - typedef enum logic[1:0] {OWN_NONE, OWN_P0, OWN_P1} boa_arb_owner_t.
// - One sub-module: boa_arb_prio (combinational 2-way priority pick from requests, priority bit
//   and starve flag). Counter and lock FSM stay in boa_mem_arbiter.
// TESTING
// - Single port: p0 reads addr 0x100 with mbus.ready=1 -> mbus.addr=0x100 same cycle;
//   p0.rdata = slave data next cycle; p1.rdata=0.
// - Contention: both read every cycle, PRIO_P1=1, STARVE_LIMIT=4 -> p1 granted 4 cycles, p0 on 5th,
//   then p1 again; starve_cnt back to 0.
// - Wait state: p0 granted, mbus.ready=0 for 3 cycles, p1 requests meanwhile -> grant stays on p0,
//   p1.ready=0; p1 granted the cycle after p0 is accepted.
// - Write pass-through: p1 we=4'b0011, addr 0x40, wdata 0xdeadbeef -> identical on mbus;
//   p0.ready=0 that cycle.
// - Reset mid-lock: rst=1 during LOCKED wait state -> next cycle state IDLE, all ready/rdata 0,
//   mbus.re/we 0.
// - Back-to-back alternation: p0 and p1 toggle requests each cycle -> every access accepted with no
//   bubble; rdata routed to the correct port each following cycle.

Source files
------------

// File: rtl/boa_mem_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter.
package boa_mem_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} boa_arb_state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} boa_arb_owner_t;

    localparam logic [3:0] STARVE_MAX = 4'd15;

    function automatic logic busRequest(input logic re, input logic [3:0] we);
        return re | (|we);
    endfunction

endpackage

// File: rtl/boa_mem_arbiter_if.sv
// boa_mem_bus signal bundle: master drives the access, slave answers with ready/rdata.
interface boa_mem_arbiter_if;

    logic        re;
    logic [3:0]  we;
    logic [31:2] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output re, we, addr, wdata, input ready, rdata);
    modport slave  (input re, we, addr, wdata, output ready, rdata);

endinterface

// File: rtl/boa_mem_arbiter_prio.sv
// Combinational 2-way pick: priority port wins a tie unless the other port is starved.
module boa_mem_arbiter_prio (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prioP1,
    input  logic i_starve,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic w_pickP1;

    always_comb begin
        w_pickP1 = i_starve ? ~i_prioP1 : i_prioP1;
        o_gnt0   = i_req0 & (~i_req1 | ~w_pickP1);
        o_gnt1   = i_req1 & (~i_req0 | w_pickP1);
    end

endmodule

// File: rtl/boa_mem_arbiter.sv
// Shares one boa_mem_bus slave between fetch (p0) and data (p1) masters,
// holding the grant through wait states and steering read data back to its issuer.
module boa_mem_arbiter
    import boa_mem_arbiter_pkg::*;
#(
    parameter int PRIO_P1      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    boa_mem_arbiter_if.slave    p0bus,
    boa_mem_arbiter_if.slave    p1bus,
    boa_mem_arbiter_if.master   mbus
);

    localparam logic       PRIO_BIT  = (PRIO_P1 != 0);
    localparam logic [3:0] LIMIT_VAL = 4'(STARVE_LIMIT);

    boa_arb_state_t r_state;
    logic           r_lockOwner;
    boa_arb_owner_t r_respOwner;
    logic [3:0]     r_starveCnt;

    logic w_req0;
    logic w_req1;
    logic w_starve;
    logic w_pick0;
    logic w_pick1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_accept0;
    logic w_accept1;
    logic w_npAccept;
    logic w_npLost;

    boa_mem_arbiter_prio u_prio (
        .i_req0   (w_req0),
        .i_req1   (w_req1),
        .i_prioP1 (PRIO_BIT),
        .i_starve (w_starve),
        .o_gnt0   (w_pick0),
        .o_gnt1   (w_pick1)
    );

    // A locked owner that drops its request loses the grant, which also releases the lock.
    always_comb begin
        w_req0   = busRequest(p0bus.re, p0bus.we);
        w_req1   = busRequest(p1bus.re, p1bus.we);
        w_starve = (r_starveCnt >= LIMIT_VAL);
        w_gnt0   = 1'b0;
        w_gnt1   = 1'b0;
        if (!rst) begin
            if (r_state == ARB_LOCKED) begin
                w_gnt0 = ~r_lockOwner & w_req0;
                w_gnt1 = r_lockOwner & w_req1;
            end else begin
                w_gnt0 = w_pick0;
                w_gnt1 = w_pick1;
            end
        end
        w_accept0  = w_gnt0 & mbus.ready;
        w_accept1  = w_gnt1 & mbus.ready;
        w_npAccept = PRIO_BIT ? w_accept0 : w_accept1;
        w_npLost   = w_req0 & w_req1 & ~(PRIO_BIT ? w_gnt0 : w_gnt1);
    end

    assign mbus.re    = (w_gnt0 & p0bus.re) | (w_gnt1 & p1bus.re);
    assign mbus.we    = ({4{w_gnt0}} & p0bus.we) | ({4{w_gnt1}} & p1bus.we);
    assign mbus.addr  = ({30{w_gnt0}} & p0bus.addr) | ({30{w_gnt1}} & p1bus.addr);
    assign mbus.wdata = ({32{w_gnt0}} & p0bus.wdata) | ({32{w_gnt1}} & p1bus.wdata);

    assign p0bus.ready = w_gnt0 & mbus.ready;
    assign p1bus.ready = w_gnt1 & mbus.ready;
    assign p0bus.rdata = (!rst && r_respOwner == OWN_P0) ? mbus.rdata : 32'h0;
    assign p1bus.rdata = (!rst && r_respOwner == OWN_P1) ? mbus.rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_lockOwner <= 1'b0;
            r_respOwner <= OWN_NONE;
            r_starveCnt <= 4'd0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if ((w_gnt0 | w_gnt1) && !mbus.ready) begin
                        r_state     <= ARB_LOCKED;
                        r_lockOwner <= w_gnt1;
                    end
                end
                ARB_LOCKED: begin
                    if (!(w_gnt0 | w_gnt1) || mbus.ready) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase

            if (w_accept0) begin
                r_respOwner <= OWN_P0;
            end else if (w_accept1) begin
                r_respOwner <= OWN_P1;
            end else begin
                r_respOwner <= OWN_NONE;
            end

            if (w_npAccept) begin
                r_starveCnt <= 4'd0;
            end else if (w_npLost && r_starveCnt != STARVE_MAX) begin
                r_starveCnt <= r_starveCnt + 4'd1;
            end
        end
    end

endmodule
